// File: rtl/cache_arb_pkg.sv
// Shared types for the I/D-cache memory arbiter.
package cache_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_GNT_I,
    ARB_GNT_D
  } arb_state_t;

  typedef enum logic {
    PORT_I,
    PORT_D
  } arb_port_t;

  localparam int LINE_BYTES = 32;

endpackage

// File: rtl/cache_mem_arbiter_if.sv
// One cacheline-wide dfp/memory port; the requester side is the master.
interface cache_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
);
  logic [ADDR_W-1:0] addr;
  logic              read;
  logic              write;
  logic [LINE_W-1:0] wdata;
  logic [LINE_W-1:0] rdata;
  logic              resp;

  modport master (output addr, read, write, wdata, input rdata, resp);
  modport slave  (input addr, read, write, wdata, output rdata, resp);
endinterface

// File: rtl/arb_rr_pick.sv
// Combinational tie-break between the I- and D-cache requests.
module arb_rr_pick
  import cache_arb_pkg::*;
(
  input  logic      ireq_i,
  input  logic      dreq_i,
  input  arb_port_t last_gnt_i,
  input  logic      prio_i,
  output arb_port_t gnt_o
);

  // Only meaningful when at least one request is set.
  always_comb begin
    gnt_o = PORT_I;
    if (ireq_i && dreq_i) begin
      gnt_o = (prio_i || last_gnt_i == PORT_I) ? PORT_D : PORT_I;
    end else if (dreq_i) begin
      gnt_o = PORT_D;
    end
  end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one cacheline memory port between the I-cache and D-cache.
// Optional perf counters are built when CACHE_ARB_PERF_EN is defined.
module cache_mem_arbiter
  import cache_arb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int LINE_W      = LINE_BYTES * 8,
  parameter int DCACHE_PRIO = 0
`ifdef CACHE_ARB_PERF_EN
  , parameter int CNT_W     = 32
`endif
) (
  input  logic                clk,
  input  logic                rst_n,
  cache_mem_arbiter_if.slave  icache,
  cache_mem_arbiter_if.slave  dcache,
  cache_mem_arbiter_if.master mem
`ifdef CACHE_ARB_PERF_EN
  , output logic [CNT_W-1:0]  i_gnt_cnt
  , output logic [CNT_W-1:0]  d_gnt_cnt
  , output logic [CNT_W-1:0]  conflict_cnt
  , output logic [CNT_W-1:0]  wait_cyc_cnt
`endif
);

  localparam logic PRIO_D = (DCACHE_PRIO != 0);

  arb_state_t        state_q, state_d;
  arb_port_t         last_gnt_q, last_gnt_d;
  arb_port_t         pick_last, pick;
  arb_state_t        pick_state;
  logic              i_req, d_req;
  logic [ADDR_W-1:0] sel_addr;
  logic [LINE_W-1:0] sel_wdata;
  logic              sel_read, sel_write;

  assign i_req = icache.read | icache.write;
  assign d_req = dcache.read | dcache.write;

  // While granted, the current owner counts as last so a tie hands over cleanly.
  always_comb begin
    pick_last = last_gnt_q;
    if (state_q == ARB_GNT_I) pick_last = PORT_I;
    if (state_q == ARB_GNT_D) pick_last = PORT_D;
  end

  arb_rr_pick u_pick (
    .ireq_i     (i_req),
    .dreq_i     (d_req),
    .last_gnt_i (pick_last),
    .prio_i     (PRIO_D),
    .gnt_o      (pick)
  );

  assign pick_state = (pick == PORT_D) ? ARB_GNT_D : ARB_GNT_I;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ARB_IDLE;
      last_gnt_q <= PORT_I;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_gnt_d   = last_gnt_q;
    icache.resp  = 1'b0;
    icache.rdata = '0;
    dcache.resp  = 1'b0;
    dcache.rdata = '0;
    unique case (state_q)
      ARB_IDLE: begin
        if (i_req || d_req) state_d = pick_state;
      end
      ARB_GNT_I: begin
        if (mem.resp) begin
          icache.resp  = 1'b1;
          icache.rdata = mem.rdata;
          last_gnt_d   = PORT_I;
          state_d      = d_req ? pick_state : ARB_IDLE;
        end
      end
      ARB_GNT_D: begin
        if (mem.resp) begin
          dcache.resp  = 1'b1;
          dcache.rdata = mem.rdata;
          last_gnt_d   = PORT_D;
          state_d      = i_req ? pick_state : ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_read  = 1'b0;
    sel_write = 1'b0;
    if (state_q == ARB_GNT_I) begin
      sel_addr  = icache.addr;
      sel_wdata = icache.wdata;
      sel_read  = icache.read;
      sel_write = icache.write;
    end else if (state_q == ARB_GNT_D) begin
      sel_addr  = dcache.addr;
      sel_wdata = dcache.wdata;
      sel_read  = dcache.read;
      sel_write = dcache.write;
    end
  end

  assign mem.addr  = sel_addr;
  assign mem.wdata = sel_wdata;
  assign mem.read  = sel_read;
  assign mem.write = sel_write;

`ifdef CACHE_ARB_PERF_EN
  logic [CNT_W-1:0] i_gnt_q, d_gnt_q, conflict_q, wait_q;
  logic             gnt_evt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // A new grant is decided either from IDLE or on a completing response.
  assign gnt_evt = (state_q == ARB_IDLE) || mem.resp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_gnt_q    <= '0;
      d_gnt_q    <= '0;
      conflict_q <= '0;
      wait_q     <= '0;
    end else begin
      if (gnt_evt && state_d == ARB_GNT_I) i_gnt_q <= sat_inc(i_gnt_q);
      if (gnt_evt && state_d == ARB_GNT_D) d_gnt_q <= sat_inc(d_gnt_q);
      if (state_q == ARB_IDLE && i_req && d_req) conflict_q <= sat_inc(conflict_q);
      if ((i_req && state_q != ARB_GNT_I) || (d_req && state_q != ARB_GNT_D))
        wait_q <= sat_inc(wait_q);
    end
  end

  assign i_gnt_cnt    = i_gnt_q;
  assign d_gnt_cnt    = d_gnt_q;
  assign conflict_cnt = conflict_q;
  assign wait_cyc_cnt = wait_q;
`endif

  a_rw_i: assert property (@(posedge clk) disable iff (!rst_n) !(icache.read && icache.write));
  a_rw_d: assert property (@(posedge clk) disable iff (!rst_n) !(dcache.read && dcache.write));
  a_hold_i: assert property (@(posedge clk) disable iff (!rst_n) (state_q == ARB_GNT_I) |-> i_req);
  a_hold_d: assert property (@(posedge clk) disable iff (!rst_n) (state_q == ARB_GNT_D) |-> d_req);

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Scoreboard bench: dut0 uses round-robin ties, dut1 gives the D-cache priority.
module tb_cache_mem_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cache_mem_arbiter_if ic0 ();
  cache_mem_arbiter_if dc0 ();
  cache_mem_arbiter_if mm0 ();
  cache_mem_arbiter_if ic1 ();
  cache_mem_arbiter_if dc1 ();
  cache_mem_arbiter_if mm1 ();

`ifdef CACHE_ARB_PERF_EN
  logic [31:0] i_gnt0, d_gnt0, conf0, wait0, i_gnt1, d_gnt1, conf1, wait1;
`endif

  cache_mem_arbiter #(.DCACHE_PRIO(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .icache(ic0), .dcache(dc0), .mem(mm0)
`ifdef CACHE_ARB_PERF_EN
    , .i_gnt_cnt(i_gnt0), .d_gnt_cnt(d_gnt0), .conflict_cnt(conf0), .wait_cyc_cnt(wait0)
`endif
  );

  cache_mem_arbiter #(.DCACHE_PRIO(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .icache(ic1), .dcache(dc1), .mem(mm1)
`ifdef CACHE_ARB_PERF_EN
    , .i_gnt_cnt(i_gnt1), .d_gnt_cnt(d_gnt1), .conflict_cnt(conf1), .wait_cyc_cnt(wait1)
`endif
  );

  typedef struct {
    logic         port;   // 0 = I, 1 = D
    logic [31:0]  addr;
    logic         wr;
    logic [255:0] wdata;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   lat = 5;
  int   mcnt = 0;
  int   m1cnt = 0;
  int   d1_cnt = 0;
  int   i1_cnt = 0;
  bit   mem_auto = 1'b1;
  bit   i_drop = 1'b0, d_drop = 1'b0, drop_i1 = 1'b0, drop_d1 = 1'b0;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // Memory model: the line returned for an address.
  function automatic logic [255:0] pat(input logic [31:0] a);
    return {8{a ^ 32'h5A5A_0000}};
  endfunction

  task automatic push0(input logic port, input logic [31:0] a, input logic wr, input logic [255:0] wd);
    exp_t e;
    e.port = port; e.addr = a; e.wr = wr; e.wdata = wd;
    q0.push_back(e);
  endtask

  // One clock: cache drops at negedge, memory responders at +1, monitors at +2, return at +3.
  task automatic cycle();
    exp_t e;
    @(negedge clk);
    if (i_drop)  begin ic0.read = 1'b0; ic0.write = 1'b0; i_drop = 1'b0; end
    if (d_drop)  begin dc0.read = 1'b0; dc0.write = 1'b0; d_drop = 1'b0; end
    if (drop_i1) begin ic1.read = 1'b0; drop_i1 = 1'b0; end
    if (drop_d1) begin dc1.read = 1'b0; drop_d1 = 1'b0; end
    #1;
    if (mem_auto) begin
      if (mm0.resp) begin
        mm0.resp = 1'b0; mm0.rdata = '0; mcnt = 0;
      end else if (mm0.read || mm0.write) begin
        mcnt++;
        if (mcnt >= lat) begin mm0.resp = 1'b1; mm0.rdata = pat(mm0.addr); end
      end else mcnt = 0;
    end
    if (mm1.resp) begin
      mm1.resp = 1'b0; mm1.rdata = '0; m1cnt = 0;
    end else if (mm1.read || mm1.write) begin
      m1cnt++;
      if (m1cnt >= 2) begin mm1.resp = 1'b1; mm1.rdata = pat(mm1.addr); end
    end else m1cnt = 0;
    #1;
    if (ic0.resp || dc0.resp) begin
      if (q0.size() == 0) chk("unexp_resp0", {ic0.resp, dc0.resp}, 2'b00);
      else begin
        e = q0.pop_front();
        chk("resp_port", {dc0.resp, ic0.resp}, e.port ? 2'b10 : 2'b01);
        chk("mem_addr", mm0.addr, e.addr);
        chk("mem_write", mm0.write, e.wr);
        chk("mem_wdata", mm0.wdata, e.wdata);
        chk("rdata", e.port ? dc0.rdata : ic0.rdata, pat(e.addr));
        chk("other_rdata", e.port ? ic0.rdata : dc0.rdata, 256'd0);
        $display("txn dut0 port=%s addr=%08h wr=%0d", e.port ? "D" : "I", e.addr, e.wr);
      end
      i_drop = ic0.resp;
      d_drop = dc0.resp;
    end
    if (ic1.resp) i1_cnt++;
    if (dc1.resp) begin
      if (q1.size() == 0) chk("unexp_resp1", dc1.resp, 1'b0);
      else begin
        e = q1.pop_front();
        chk("p1_mem_addr", mm1.addr, e.addr);
        chk("p1_rdata", dc1.rdata, pat(e.addr));
        d1_cnt++;
        $display("txn dut1 port=D addr=%08h n=%0d", e.addr, d1_cnt);
        if (d1_cnt == 2) drop_i1 = 1'b1;
        if (d1_cnt == 3) drop_d1 = 1'b1;
      end
    end
    #1;
  endtask

  task automatic wait_q0(input int n);
    int k = 0;
    while (q0.size() > n && k < 300) begin cycle(); k++; end
    chk($sformatf("wait_q0_%0d", n), q0.size(), n);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ic0.read = 1'b0; ic0.write = 1'b0; dc0.read = 1'b0; dc0.write = 1'b0;
    mm0.resp = 1'b0; mm0.rdata = '0; mcnt = 0;
    cycle();
    rst_n = 1'b1;
  endtask

  initial begin
    exp_t e1;
    int k;
    ic0.addr = '0; ic0.read = 1'b0; ic0.write = 1'b0; ic0.wdata = '0;
    dc0.addr = '0; dc0.read = 1'b0; dc0.write = 1'b0; dc0.wdata = '0;
    ic1.addr = '0; ic1.read = 1'b0; ic1.write = 1'b0; ic1.wdata = '0;
    dc1.addr = '0; dc1.read = 1'b0; dc1.write = 1'b0; dc1.wdata = '0;
    mm0.rdata = '0; mm0.resp = 1'b0; mm1.rdata = '0; mm1.resp = 1'b0;

    // Reset held with a pending I read, then released.
    ic0.addr = 32'h0000_0100; ic0.read = 1'b1;
    cycle(); cycle();
    chk("rst_mem_read", mm0.read, 1'b0);
    chk("rst_i_resp", ic0.resp, 1'b0);
    chk("rst_i_rdata", ic0.rdata, 256'd0);
    rst_n = 1'b1;
    push0(1'b0, 32'h0000_0100, 1'b0, '0);
    #1 chk("t1_arb_cycle", mm0.read, 1'b0);
    cycle();
    chk("t1_mem_read", mm0.read, 1'b1);
    chk("t1_mem_addr", mm0.addr, 32'h0000_0100);
    wait_q0(0);

    // DCACHE_PRIO=1: D wins every tie while both request.
    cycle();
    ic1.addr = 32'h0000_2000; dc1.addr = 32'h0000_3000;
    ic1.read = 1'b1; dc1.read = 1'b1;
    e1.port = 1'b1; e1.addr = 32'h0000_3000; e1.wr = 1'b0; e1.wdata = '0;
    repeat (3) q1.push_back(e1);
    k = 0;
    while (q1.size() > 0 && k < 200) begin cycle(); k++; end
    chk("t4_d_grants", d1_cnt, 3);
    repeat (3) cycle();
    chk("t4_idle", mm1.read, 1'b0);
    chk("t4_no_i_resp", i1_cnt, 0);

    // Single D write.
    dc0.addr = 32'h0000_1040; dc0.write = 1'b1; dc0.wdata = {32{8'hA5}};
    push0(1'b1, 32'h0000_1040, 1'b1, {32{8'hA5}});
    wait_q0(0);
    cycle(); cycle();
    chk("t2_idle_write", mm0.write, 1'b0);
    chk("t2_idle_read", mm0.read, 1'b0);

    // Stray response in IDLE, then reset during GNT_I.
    mem_auto = 1'b0;
    mm0.resp = 1'b1; mm0.rdata = pat(32'h0000_0BAD);
    #1;
    chk("t5_stray_i", ic0.resp, 1'b0);
    chk("t5_stray_d", dc0.resp, 1'b0);
    chk("t5_stray_rdata", ic0.rdata, 256'd0);
    cycle();
    mm0.resp = 1'b0; mm0.rdata = '0;
    ic0.addr = 32'h0000_4000; ic0.read = 1'b1;
    cycle(); cycle();
    chk("t5_granted", mm0.read, 1'b1);
    rst_n = 1'b0;
    #1 chk("t5_async_drop", mm0.read, 1'b0);
    ic0.read = 1'b0;
    cycle();
    rst_n = 1'b1;
    cycle();
    chk("t5_idle_after_rst", mm0.read, 1'b0);
    mem_auto = 1'b1; mcnt = 0;
    dc0.addr = 32'h0000_5000; dc0.write = 1'b0; dc0.read = 1'b1; dc0.wdata = '0;
    push0(1'b1, 32'h0000_5000, 1'b0, '0);
    wait_q0(0);

    // Round-robin tie twice after reset: D first, then I with no bubble.
    do_reset();
    for (int rep = 0; rep < 2; rep++) begin
      cycle();
      ic0.addr = 32'h0000_6000 + 32'(rep * 64); ic0.read = 1'b1;
      dc0.addr = 32'h0000_7000 + 32'(rep * 64); dc0.read = 1'b1;
      push0(1'b1, 32'h0000_7000 + 32'(rep * 64), 1'b0, '0);
      push0(1'b0, 32'h0000_6000 + 32'(rep * 64), 1'b0, '0);
      wait_q0(1);
      cycle();
      chk("t3_handoff_read", mm0.read, 1'b1);
      chk("t3_handoff_addr", mm0.addr, 32'h0000_6000 + 32'(rep * 64));
      wait_q0(0);
    end
`ifdef CACHE_ARB_PERF_EN
    cycle();
    chk("perf_i_gnt", i_gnt0, 32'd2);
    chk("perf_d_gnt", d_gnt0, 32'd2);
    chk("perf_conflict", conf0, 32'd2);
`endif

    repeat (2) cycle();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
